safe_access_ctrl: RTL and testbench
===================================

Name: safe_access_ctrl

Overview:
Front-end controller for the 4-digit keypad safe. It arbitrates round-robin among NUM_REQ code requesters and serialises each accepted 16-bit code into the safe's nibble-wide din/din_valid interface. It then samples the safe's unlocked output, returns a pass/fail response, and drives the safe's reset to clear the LOCKOUT or UNLOCKED states. It also enforces a lockout cooldown after MAX_FAILS consecutive failed attempts.

Parameters:
NUM_REQ, 2, number of requesters (1..8)
MAX_FAILS, 3, consecutive failures that trigger cooldown (>=1)
COOLDOWN_CYCLES, 16, base cooldown length in clk cycles (>=1)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
req_valid  in  NUM_REQ  per-requester code offer
req_code  in  16*NUM_REQ  per-requester code; requester i uses bits [16i+15:16i]
req_ready  out  NUM_REQ  one-hot accept pulse; transfer happens when valid and ready are both high
resp_valid  out  1  one-cycle result pulse
resp_id  out  3  index of the requester being answered
resp_ok  out  1  1 = code accepted (safe unlocked)
safe_din  out  4  digit to the safe
safe_din_valid  out  1  digit strobe to the safe
safe_reset  out  1  reset to the safe
safe_unlocked  in  1  unlocked output of the safe
relock  in  1  pulse; closes an open safe
door_open  out  1  safe currently unlocked
locked_out  out  1  cooldown active
fail_count  out  4  consecutive failure count

Behaviour:
- State register reset value: CLEAR.
- Output reset values: req_ready=0, resp_valid=0, resp_id=0, resp_ok=0, safe_din=0, safe_din_valid=0, door_open=0, locked_out=0, fail_count=0.
- safe_reset = reset OR (state==CLEAR). It is combinational and drives the safe directly.
- Round-robin pointer last_grant resets to NUM_REQ-1, so requester 0 has first priority.
- States:
  - CLEAR: drives safe_reset for 1 cycle, then -> IDLE.
  - IDLE: search req_valid starting at last_grant+1, wrapping. On a hit i: req_ready[i]=1 this cycle, latch code and id, set last_grant=i, -> SEND. No hit: stay in IDLE, all req_ready=0.
  - SEND: 4 cycles with safe_din_valid=1. safe_din carries code[15:12], code[11:8], code[7:4], code[3:0] in that order. The 2-bit digit counter wraps 3->0 and the state then -> CHECK.
  - CHECK: 1 cycle. resp_valid=1, resp_id=latched id, resp_ok=safe_unlocked.
    - ok: fail_count cleared, -> OPEN.
    - fail with fail_count+1 < MAX_FAILS: increment fail_count, -> CLEAR.
    - fail with fail_count+1 == MAX_FAILS: fail_count=MAX_FAILS, load the timer, -> COOLDOWN.
  - OPEN: door_open=1; no requests accepted. On relock=1: -> CLEAR, door_open drops the next cycle.
  - COOLDOWN: locked_out=1; no requests accepted; timer decrements each cycle. After timer expiry (exactly COOLDOWN_CYCLES cycles in COOLDOWN): fail_count cleared, -> CLEAR.
- Latency: accept at cycle T; digits at T+1..T+4; resp_valid at T+5. Next accept is no earlier than T+7 after a failure (CLEAR at T+6).
- req_ready is asserted only in IDLE and is never asserted to a requester with req_valid=0.
- Requesters hold req_valid and req_code until accepted. A req_valid withdrawn before acceptance is simply not granted.
- relock in any state other than OPEN: ignored.
- A requester's valid that stays high during OPEN or COOLDOWN is served when the block returns to IDLE.
- reset mid-SEND or mid-COOLDOWN: state -> CLEAR, all counters cleared, no resp_valid issued for the aborted attempt.
- fail_count saturates at MAX_FAILS and never wraps.

Optional Feature:
SAFE_ACCESS_CTRL_ESCALATE_EN:
- Defined: each consecutive cooldown doubles in length: COOLDOWN_CYCLES, 2x, 4x, then capped at 8x. A 2-bit escalation level increments on entry to COOLDOWN and clears on a successful unlock or on reset.
- Undefined: every cooldown lasts exactly COOLDOWN_CYCLES; no escalation state is present.

Test Plan:
- Req0 offers 16'hC0DE with a correct safe -> safe_din sequence C,0,D,E on T+1..T+4; resp_valid at T+5 with resp_id=0, resp_ok=1; door_open=1; relock -> safe_reset pulse, door_open=0.
- Req1 offers 16'h1234 -> resp_ok=0, fail_count=1, one-cycle safe_reset pulse, back to IDLE.
- Three consecutive bad codes (MAX_FAILS=3) -> locked_out=1 for 16 cycles; req_ready stays 0 throughout; then fail_count=0 and a safe_reset pulse.
- req_valid=2'b11 held continuously -> grants alternate 0,1,0,1 on successive attempts.
- reset asserted on the 2nd SEND cycle -> no resp_valid, safe_reset high, IDLE 2 cycles after reset deasserts.
- With ESCALATE_EN, two lockout episodes -> cooldowns of 16 then 32 cycles; a correct code afterwards resets the next cooldown to 16.

Source files
------------

// File: rtl/safe_access_ctrl.sv
// Round-robin front end for the 4-digit keypad safe: serialises codes, reports pass/fail, enforces lockout.
// Optional macro SAFE_ACCESS_CTRL_ESCALATE_EN doubles each consecutive cooldown (capped at 8x).
module safe_access_ctrl #(
    parameter int NUM_REQ         = 2,
    parameter int MAX_FAILS       = 3,
    parameter int COOLDOWN_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [16*NUM_REQ-1:0] req_code,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic                  resp_valid,
    output logic [2:0]            resp_id,
    output logic                  resp_ok,
    output logic [3:0]            safe_din,
    output logic                  safe_din_valid,
    output logic                  safe_reset,
    input  logic                  safe_unlocked,
    input  logic                  relock,
    output logic                  door_open,
    output logic                  locked_out,
    output logic [3:0]            fail_count
);

    localparam int         TW        = $clog2(8 * COOLDOWN_CYCLES + 1);
    localparam logic [2:0] LAST_INIT = 3'(NUM_REQ - 1);
    localparam logic [4:0] MAX_F5    = 5'(MAX_FAILS);

    typedef enum logic [2:0] {
        S_CLEAR    = 3'd0,
        S_IDLE     = 3'd1,
        S_SEND     = 3'd2,
        S_CHECK    = 3'd3,
        S_OPEN     = 3'd4,
        S_COOLDOWN = 3'd5
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [2:0]    r_last;
    logic [2:0]    r_id;
    logic [2:0]    w_sel;
    logic          w_hit;
    logic [15:0]   r_code;
    logic [15:0]   w_code;
    logic [1:0]    r_digit;
    logic [3:0]    r_fail;
    logic [TW-1:0] r_timer;
    logic [TW-1:0] w_load;
    logic          w_fail_sat;

`ifdef SAFE_ACCESS_CTRL_ESCALATE_EN
    logic [1:0]    r_level;
    assign w_load = (TW'(COOLDOWN_CYCLES) << r_level) - TW'(1);
`else
    assign w_load = TW'(COOLDOWN_CYCLES - 1);
`endif

    assign w_fail_sat = (5'(r_fail) + 5'd1) >= MAX_F5;
    assign fail_count = r_fail;

    // Round-robin pick: lowest index above last_grant wins, else lowest index at or below it.
    always_comb begin
        w_hit  = 1'b0;
        w_sel  = 3'd0;
        w_code = 16'd0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i] && (3'(i) <= r_last)) begin
                w_hit = 1'b1;
                w_sel = 3'(i);
            end else begin
                w_hit = w_hit;
            end
        end
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i] && (3'(i) > r_last)) begin
                w_hit = 1'b1;
                w_sel = 3'(i);
            end else begin
                w_hit = w_hit;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_sel == 3'(i)) begin
                w_code = req_code[16*i +: 16];
            end else begin
                w_code = w_code;
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_CLEAR;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_CLEAR:    w_next = S_IDLE;
            S_IDLE:     w_next = w_hit ? S_SEND : S_IDLE;
            S_SEND:     w_next = (r_digit == 2'd3) ? S_CHECK : S_SEND;
            S_CHECK: begin
                if (safe_unlocked) begin
                    w_next = S_OPEN;
                end else if (w_fail_sat) begin
                    w_next = S_COOLDOWN;
                end else begin
                    w_next = S_CLEAR;
                end
            end
            S_OPEN:     w_next = relock ? S_CLEAR : S_OPEN;
            S_COOLDOWN: w_next = (r_timer == '0) ? S_CLEAR : S_COOLDOWN;
            default:    w_next = S_CLEAR;
        endcase
    end

    // Datapath: latched code/id, digit counter, failure count, cooldown timer.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last  <= LAST_INIT;
            r_id    <= 3'd0;
            r_code  <= 16'd0;
            r_digit <= 2'd0;
            r_fail  <= 4'd0;
            r_timer <= '0;
`ifdef SAFE_ACCESS_CTRL_ESCALATE_EN
            r_level <= 2'd0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_hit) begin
                        r_code  <= w_code;
                        r_id    <= w_sel;
                        r_last  <= w_sel;
                        r_digit <= 2'd0;
                    end else begin
                        r_digit <= 2'd0;
                    end
                end
                S_SEND: r_digit <= r_digit + 2'd1;
                S_CHECK: begin
                    if (safe_unlocked) begin
                        r_fail <= 4'd0;
`ifdef SAFE_ACCESS_CTRL_ESCALATE_EN
                        r_level <= 2'd0;
`endif
                    end else if (w_fail_sat) begin
                        r_fail  <= 4'(MAX_FAILS);
                        r_timer <= w_load;
`ifdef SAFE_ACCESS_CTRL_ESCALATE_EN
                        r_level <= (r_level == 2'd3) ? 2'd3 : r_level + 2'd1;
`endif
                    end else begin
                        r_fail <= r_fail + 4'd1;
                    end
                end
                S_COOLDOWN: begin
                    if (r_timer == '0) begin
                        r_fail <= 4'd0;
                    end else begin
                        r_timer <= r_timer - TW'(1);
                    end
                end
                default: r_digit <= r_digit;
            endcase
        end
    end

    // Outputs decoded from state; safe_reset also follows the block reset directly.
    always_comb begin
        req_ready      = '0;
        resp_valid     = 1'b0;
        resp_id        = 3'd0;
        resp_ok        = 1'b0;
        safe_din       = 4'd0;
        safe_din_valid = 1'b0;
        door_open      = 1'b0;
        locked_out     = 1'b0;
        safe_reset     = reset | (r_state == S_CLEAR);
        case (r_state)
            S_IDLE: begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    req_ready[i] = w_hit && (w_sel == 3'(i));
                end
            end
            S_SEND: begin
                safe_din_valid = 1'b1;
                case (r_digit)
                    2'd0:    safe_din = r_code[15:12];
                    2'd1:    safe_din = r_code[11:8];
                    2'd2:    safe_din = r_code[7:4];
                    default: safe_din = r_code[3:0];
                endcase
            end
            S_CHECK: begin
                resp_valid = 1'b1;
                resp_id    = r_id;
                resp_ok    = safe_unlocked;
            end
            S_OPEN:     door_open  = 1'b1;
            S_COOLDOWN: locked_out = 1'b1;
            default:    resp_valid = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_safe_access_ctrl.sv
// Scoreboard bench for safe_access_ctrl with a behavioural 4-digit safe (secret 16'hC0DE).
module tb_safe_access_ctrl;

    localparam int          NREQ   = 2;
    localparam int          MAXF   = 3;
    localparam int          CD     = 16;
    localparam logic [15:0] SECRET = 16'hC0DE;

    logic            clk = 1'b0;
    logic            reset;
    logic [NREQ-1:0] req_valid;
    logic [31:0]     req_code;
    logic [NREQ-1:0] req_ready;
    logic            resp_valid;
    logic [2:0]      resp_id;
    logic            resp_ok;
    logic [3:0]      safe_din;
    logic            safe_din_valid;
    logic            safe_reset;
    logic            safe_unlocked;
    logic            relock;
    logic            door_open;
    logic            locked_out;
    logic [3:0]      fail_count;

    int n_checks = 0;
    int n_fails  = 0;

    logic [3:0]  exp_din[$];
    logic [3:0]  exp_resp[$];
    logic [15:0] code_r[0:1];
    int          model_fail = 0;
    int          model_lvl  = 0;
    int          model_cd   = CD;
    logic [15:0] sh  = 16'd0;
    int          cnt = 0;

    safe_access_ctrl #(.NUM_REQ(NREQ), .MAX_FAILS(MAXF), .COOLDOWN_CYCLES(CD)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_code(req_code),
        .req_ready(req_ready), .resp_valid(resp_valid), .resp_id(resp_id), .resp_ok(resp_ok),
        .safe_din(safe_din), .safe_din_valid(safe_din_valid), .safe_reset(safe_reset),
        .safe_unlocked(safe_unlocked), .relock(relock), .door_open(door_open),
        .locked_out(locked_out), .fail_count(fail_count)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Safe model plus scoreboard pops for digits and responses.
    always @(negedge clk) begin
        logic [3:0] e;
        if (safe_reset) begin
            sh = 16'd0; cnt = 0; safe_unlocked = 1'b0;
        end else if (safe_din_valid) begin
            sh  = {sh[11:0], safe_din};
            cnt = cnt + 1;
            if (cnt == 4) safe_unlocked = (sh == SECRET);
        end
        if (safe_din_valid) begin
            if (exp_din.size() == 0) check_val("din_unexpected", 32'd1, 32'd0);
            else begin
                e = exp_din.pop_front();
                check_val("din", 32'(safe_din), 32'(e));
            end
        end
        if (resp_valid) begin
            if (exp_resp.size() == 0) check_val("resp_unexpected", 32'd1, 32'd0);
            else begin
                e = exp_resp.pop_front();
                check_val("resp_ok_id", 32'({resp_ok, resp_id}), 32'(e));
            end
        end
    end

    task automatic offer(input int id, input logic [15:0] c);
        code_r[id]           = c;
        req_code[16*id +: 16] = c;
        req_valid[id]        = 1'b1;
    endtask

    // Wait for a grant to 'id', score the transfer, and stop at the cycle after the response.
    task automatic serve(input int id, input bit drop);
        bit          got;
        bit          ok;
        logic [15:0] c;
        got = 1'b0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            #1;
            if (req_ready != '0) begin got = 1'b1; break; end
            @(negedge clk);
        end
        check_val("grant", 32'(req_ready), 32'd1 << id);
        if (!got) return;
        c  = code_r[id];
        ok = (c == SECRET);
        exp_din.push_back(c[15:12]); exp_din.push_back(c[11:8]);
        exp_din.push_back(c[7:4]);   exp_din.push_back(c[3:0]);
        exp_resp.push_back({ok, 3'(id)});
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            check_val("din_valid_slot", 32'(safe_din_valid), 32'd1);
            if (k == 1 && drop) req_valid[id] = 1'b0;
        end
        @(negedge clk);
        check_val("resp_valid_slot", 32'(resp_valid), 32'd1);
        if (ok) begin
            model_fail = 0; model_lvl = 0;
        end else if (model_fail + 1 < MAXF) begin
            model_fail++;
        end else begin
            model_fail = MAXF;
`ifdef SAFE_ACCESS_CTRL_ESCALATE_EN
            model_cd = CD << model_lvl;
            if (model_lvl < 3) model_lvl++;
`else
            model_cd = CD;
`endif
        end
        @(negedge clk);
        check_val("fail_count", 32'(fail_count), 32'(model_fail));
        check_val("door_open", 32'(door_open), 32'(ok));
        check_val("locked_out", 32'(locked_out), 32'(!ok && model_fail == MAXF));
        check_val("clear_after_fail", 32'(safe_reset), 32'(!ok && model_fail != MAXF));
    endtask

    task automatic relock_seq();
        relock = 1'b1;
        @(negedge clk);
        check_val("relock_door", 32'(door_open), 32'd0);
        check_val("relock_safe_reset", 32'(safe_reset), 32'd1);
        relock = 1'b0;
        @(negedge clk);
        check_val("relock_pulse_end", 32'(safe_reset), 32'd0);
    endtask

    // Called on the first cooldown cycle; measures its length with a blocked requester waiting.
    task automatic cooldown_watch(input int exp_len);
        int len;
        int bad_ready;
        len = 1; bad_ready = 0;
        offer(1, 16'h5555);
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (!locked_out) break;
            len++;
            if (req_ready != '0) bad_ready++;
        end
        req_valid[1] = 1'b0;
        check_val("cooldown_len", 32'(len), 32'(exp_len));
        check_val("ready_in_cooldown", 32'(bad_ready), 32'd0);
        check_val("cooldown_exit_reset", 32'(safe_reset), 32'd1);
        check_val("cooldown_exit_fails", 32'(fail_count), 32'd0);
        model_fail = 0;
    endtask

    task automatic episode();
        for (int n = 0; n < MAXF; n++) begin
            offer(0, 16'h0BAD);
            serve(0, 1'b1);
        end
        cooldown_watch(model_cd);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; req_valid = '0; req_code = 32'd0; relock = 1'b0; safe_unlocked = 1'b0;
        code_r[0] = 16'd0; code_r[1] = 16'd0;
        @(negedge clk); @(negedge clk);
        check_val("rst_safe_reset", 32'(safe_reset), 32'd1);
        check_val("rst_ready", 32'(req_ready), 32'd0);
        check_val("rst_outputs", 32'({resp_valid, resp_id, resp_ok, safe_din, safe_din_valid,
                                      door_open, locked_out}), 32'd0);
        check_val("rst_fail_count", 32'(fail_count), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check_val("idle_safe_reset", 32'(safe_reset), 32'd0);
        relock = 1'b1;
        @(negedge clk);
        check_val("relock_ignored", 32'(safe_reset), 32'd0);
        relock = 1'b0;

        // Correct code, then a second requester waits through OPEN.
        offer(0, SECRET);
        serve(0, 1'b1);
        offer(1, 16'h1234);
        @(negedge clk);
        check_val("ready_in_open", 32'(req_ready), 32'd0);
        check_val("door_held", 32'(door_open), 32'd1);
        relock_seq();

        // Single failure.
        serve(1, 1'b1);
        @(negedge clk);
        check_val("clear_pulse_end", 32'(safe_reset), 32'd0);

        // Two more failures reach the lockout.
        offer(0, 16'h1111);
        serve(0, 1'b1);
        offer(1, 16'h2222);
        serve(1, 1'b1);
        cooldown_watch(model_cd);

        // Both requesters held continuously: grants alternate.
        offer(0, SECRET);
        offer(1, SECRET);
        for (int a = 0; a < 4; a++) begin
            serve(a % 2, 1'b0);
            relock_seq();
        end
        req_valid = '0;

        // Reset on the second SEND cycle aborts the attempt.
        offer(0, 16'h3333);
        for (int cyc = 0; cyc < 20; cyc++) begin
            #1;
            if (req_ready != '0) break;
            @(negedge clk);
        end
        check_val("abort_grant", 32'(req_ready), 32'd1);
        exp_din.push_back(4'h3); exp_din.push_back(4'h3);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1; req_valid = '0;
        @(negedge clk);
        check_val("abort_no_resp", 32'(resp_valid), 32'd0);
        check_val("abort_safe_reset", 32'(safe_reset), 32'd1);
        check_val("abort_din_valid", 32'(safe_din_valid), 32'd0);
        reset = 1'b0;
        model_fail = 0; model_lvl = 0;
        @(negedge clk);
        check_val("abort_idle", 32'(safe_reset), 32'd0);
        repeat (6) @(negedge clk);
        check_val("abort_q_empty", 32'(exp_din.size() + exp_resp.size()), 32'd0);

        // Two lockout episodes, a correct code, then a third episode.
        episode();
        episode();
        offer(0, SECRET);
        serve(0, 1'b1);
        relock_seq();
        episode();

        repeat (4) @(negedge clk);
        check_val("final_q_empty", 32'(exp_din.size() + exp_resp.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
